// File: rtl/demux1_4_reg_if.sv
// Handshake bundle between one producer and four consumer channels of the
// registered 1-to-4 demultiplexer.
interface demux1_4_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );
endinterface

// File: rtl/demux1_4_reg.sv
// Registered 1-to-4 stream demultiplexer: each channel owns a one-entry
// holding register so the four consumers drain independently.
//
// state | meaning
// EMPTY | channel holds no word, out_valid[k]=0
// FULL  | channel holds a word awaiting out_ready[k]
module demux1_4_reg #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  demux1_4_reg_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t        state_q [4];
  ch_state_t        state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [3:0]       load;
  logic [3:0]       valid;
  logic             ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) state_q[k] <= EMPTY;
    end else begin
      for (int k = 0; k < 4; k++) state_q[k] <= state_d[k];
    end
  end

  // A load to a draining channel keeps it FULL, so a single always-ready
  // consumer sees one word per cycle without bubbles.
  always_comb begin
    ready = (state_q[bus.in_sel] == EMPTY) | bus.out_ready[bus.in_sel];
    load  = 4'b0000;
    valid = 4'b0000;
    if (bus.in_valid && ready) load[bus.in_sel] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      valid[k]   = (state_q[k] == FULL);
      if (load[k])
        state_d[k] = FULL;
      else if (state_q[k] == FULL && bus.out_ready[k])
        state_d[k] = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (load[k]) data_q[k] <= bus.in_data;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];

endmodule

// File: tb/tb_demux1_4_reg.sv
// Self-checking bench for demux1_4_reg: behavioural channel model plus
// directed scenarios and randomized traffic.
module tb_demux1_4_reg;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  demux1_4_reg_if #(.WIDTH(WIDTH)) bus ();

  demux1_4_reg #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: each channel is simply "holding a word or not" plus the word.
  bit         m_full [4];
  logic [31:0] m_word [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 0;
        m_word[k] = '0;
      end
    end else begin
      bit       take;
      int       s;
      s    = int'(bus.in_sel);
      take = bus.in_valid && (!m_full[s] || bus.out_ready[s]);
      for (int k = 0; k < 4; k++)
        if (m_full[k] && bus.out_ready[k]) m_full[k] = 0;
      if (take) begin
        m_full[s] = 1;
        m_word[s] = bus.in_data;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_word(input int k);
    case (k)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  // Compare process: every negedge out of reset, DUT must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] ev;
      int         s;
      s = int'(bus.in_sel);
      for (int k = 0; k < 4; k++) ev[k] = m_full[k];
      chk("model_out_valid", {28'd0, bus.out_valid}, {28'd0, ev});
      chk("model_in_ready", {31'd0, bus.in_ready},
          {31'd0, (!m_full[s] || bus.out_ready[s])});
      for (int k = 0; k < 4; k++) chk("model_out_data", dut_word(k), m_word[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {28'd0, bus.out_valid}, 32'd0);
    chk("reset_out_data0", bus.out_data0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Routing to all four channels
    for (int k = 0; k < 4; k++) send(2'(k), 32'hA0 + 32'(k));
    chk("route_valid", {28'd0, bus.out_valid}, 32'hF);
    chk("route_d0", bus.out_data0, 32'hA0);
    chk("route_d1", bus.out_data1, 32'hA1);
    chk("route_d2", bus.out_data2, 32'hA2);
    chk("route_d3", bus.out_data3, 32'hA3);
    bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 32'hBB;
    #1;
    chk("route_full_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    bus.in_valid = 1'b0;
    chk("route_no_overwrite", bus.out_data2, 32'hA2);

    // All four drain in one cycle
    bus.out_ready = 4'b1111;
    step();
    bus.out_ready = 4'b0000;
    chk("drain_all", {28'd0, bus.out_valid}, 32'd0);

    // Backpressure hold
    send(2'd1, 32'h55);
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 32'h66;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold", bus.out_data1, 32'h55);
      step();
    end
    bus.out_ready = 4'b0010;
    #1;
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
    chk("bp_new_word", bus.out_data1, 32'h66);
    chk("bp_new_valid", {31'd0, bus.out_valid[1]}, 32'd1);
    bus.out_ready = 4'b1111;
    step();

    // Streaming to an always-ready channel
    bus.out_ready = 4'b1000;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.in_data = 32'(i);
      #1;
      chk("stream_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      chk("stream_data", bus.out_data3, 32'(i));
      chk("stream_valid", {31'd0, bus.out_valid[3]}, 32'd1);
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 4'b0000;

    // Load wins over simultaneous drain
    send(2'd0, 32'h11);
    bus.out_ready = 4'b0001;
    send(2'd0, 32'h22);
    bus.out_ready = 4'b0000;
    chk("loadwins_valid", {31'd0, bus.out_valid[0]}, 32'd1);
    chk("loadwins_data", bus.out_data0, 32'h22);

    // out_ready on an empty channel does nothing
    bus.out_ready = 4'b0100;
    step();
    bus.out_ready = 4'b0000;
    chk("idle_valid", {31'd0, bus.out_valid[2]}, 32'd0);
    chk("idle_data", bus.out_data2, 32'hA2);

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_sel    = 2'($urandom_range(0, 3));
      bus.in_data   = $urandom;
      bus.out_ready = 4'($urandom_range(0, 15));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;

    // Async reset mid-stream with channels full
    for (int k = 0; k < 4; k++) send(2'(k), 32'hC0 + 32'(k));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {28'd0, bus.out_valid}, 32'd0);
    chk("async_rst_d0", bus.out_data0, 32'd0);
    chk("async_rst_d1", bus.out_data1, 32'd0);
    chk("async_rst_d2", bus.out_data2, 32'd0);
    chk("async_rst_d3", bus.out_data3, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_valid", {28'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd2, 32'h77);
    chk("post_rst_valid", {28'd0, bus.out_valid}, 32'h4);
    chk("post_rst_d2", bus.out_data2, 32'h77);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
